// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage fields in, pipeline enables/flushes/forwarding selects out
interface hazard_ctrl_if;
  logic       i_id_vld;
  logic [4:0] i_id_rs1_addr;
  logic [4:0] i_id_rs2_addr;
  logic       i_id_rs1_use;
  logic       i_id_rs2_use;
  logic [4:0] i_id_rd_addr;
  logic       i_id_rd_wren;
  logic       i_id_isload;
  logic       i_ex_mispred;
  logic       i_mem_busy;
  logic       o_pc_en;
  logic       o_if_id_en;
  logic       o_if_id_flush;
  logic       o_id_ex_en;
  logic       o_id_ex_flush;
  logic [1:0] o_fwd_a_sel;
  logic [1:0] o_fwd_b_sel;

  // Pipeline side: supplies decoded fields and status, consumes controls
  modport master (
    output i_id_vld, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_use, i_id_rs2_use,
           i_id_rd_addr, i_id_rd_wren, i_id_isload, i_ex_mispred, i_mem_busy,
    input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
           o_fwd_a_sel, o_fwd_b_sel
  );

  // Controller side
  modport slave (
    input  i_id_vld, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_use, i_id_rs2_use,
           i_id_rd_addr, i_id_rd_wren, i_id_isload, i_ex_mispred, i_mem_busy,
    output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
           o_fwd_a_sel, o_fwd_b_sel
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage hazard controller (load-use, mispredict, LSU freeze); HAZARD_PERF_EN adds counters
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  hazard_ctrl_if.slave     bus,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_LDUSE  = 2'b01;
  localparam logic [1:0] ST_FREEZE = 2'b10;

  // Shadow copy of the destination state of the instructions in EX and MEM
  logic       ex_vld_q, ex_wren_q, ex_isload_q;
  logic [4:0] ex_rd_q;
  logic       mem_vld_q, mem_wren_q;
  logic [4:0] mem_rd_q;

  logic [1:0] state_q, state_d, prev_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, ld_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;

  // Operand match of the ID instruction against the producers in EX and MEM
  always_comb begin
    ex_hit_a  = bus.i_id_vld && bus.i_id_rs1_use && ex_vld_q && ex_wren_q &&
                (ex_rd_q != 5'd0) && (ex_rd_q == bus.i_id_rs1_addr);
    ex_hit_b  = bus.i_id_vld && bus.i_id_rs2_use && ex_vld_q && ex_wren_q &&
                (ex_rd_q != 5'd0) && (ex_rd_q == bus.i_id_rs2_addr);
    mem_hit_a = bus.i_id_vld && bus.i_id_rs1_use && mem_vld_q && mem_wren_q &&
                (mem_rd_q != 5'd0) && (mem_rd_q == bus.i_id_rs1_addr);
    mem_hit_b = bus.i_id_vld && bus.i_id_rs2_use && mem_vld_q && mem_wren_q &&
                (mem_rd_q != 5'd0) && (mem_rd_q == bus.i_id_rs2_addr);
    ld_use    = ex_isload_q && (ex_hit_a || ex_hit_b);
  end

  // Enables, flushes and next state in priority order: reset, freeze, mispredict, load-use
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    state_d     = ST_RUN;
    if (i_reset) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (bus.i_mem_busy) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
      state_d  = ST_FREEZE;
    end else if (bus.i_ex_mispred) begin
      // Redirect wins over a coincident load-use: the consumer is squashed anyway
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ld_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = ST_LDUSE;
    end else if (state_q == ST_FREEZE) begin
      state_d = prev_q;
    end
  end

  // Forwarding select for the instruction about to enter EX; youngest producer first
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!id_ex_flush) begin
      if (ex_hit_a)       fwd_a_d = 2'b01;
      else if (mem_hit_a) fwd_a_d = 2'b10;
      if (ex_hit_b)       fwd_b_d = 2'b01;
      else if (mem_hit_b) fwd_b_d = 2'b10;
    end
  end

  // Shadow tracking advances on every non-frozen cycle; a flush or bubble enters EX empty
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_vld_q    <= 1'b0;
      ex_wren_q   <= 1'b0;
      ex_isload_q <= 1'b0;
      ex_rd_q     <= 5'd0;
      mem_vld_q   <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_rd_q    <= 5'd0;
    end else if (!bus.i_mem_busy) begin
      mem_vld_q  <= ex_vld_q;
      mem_wren_q <= ex_wren_q;
      mem_rd_q   <= ex_rd_q;
      if (id_ex_flush || !bus.i_id_vld) begin
        ex_vld_q    <= 1'b0;
        ex_wren_q   <= 1'b0;
        ex_isload_q <= 1'b0;
        ex_rd_q     <= 5'd0;
      end else begin
        ex_vld_q    <= 1'b1;
        ex_wren_q   <= bus.i_id_rd_wren;
        ex_isload_q <= bus.i_id_isload;
        ex_rd_q     <= bus.i_id_rd_addr;
      end
    end
  end

  // State register, plus the state to resume once the LSU releases the freeze
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      prev_q  <= ST_RUN;
    end else begin
      state_q <= state_d;
      if (bus.i_mem_busy && (state_q != ST_FREEZE)) prev_q <= state_q;
    end
  end

  // Forwarding selects load with ID/EX and hold while it is frozen
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (id_ex_en) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters: stall entries and taken mispredicts
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.i_mem_busy) begin
      if (!bus.i_ex_mispred && ld_use && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (bus.i_ex_mispred && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

  assign bus.o_pc_en       = pc_en;
  assign bus.o_if_id_en    = if_id_en;
  assign bus.o_if_id_flush = if_id_flush;
  assign bus.o_id_ex_en    = id_ex_en;
  assign bus.o_id_ex_flush = id_ex_flush;
  assign bus.o_fwd_a_sel   = fwd_a_q;
  assign bus.o_fwd_b_sel   = fwd_b_q;
  assign o_state           = state_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It takes the decoded ID-stage fields from the control decoder, keeps its own shadow copy of destination-register state for the EX and MEM stages, and drives the pipeline-register enables, flushes and registered forwarding selects. It owns three hazard cases: load-use stalls, mispredict flushes from the branch predictor path, and LSU freeze.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high
- i_id_vld  in  1  ID holds a valid instruction (decoder insn_vld, not a bubble)
- i_id_rs1_addr / i_id_rs2_addr  in  5 each  ID source registers
- i_id_rs1_use / i_id_rs2_use  in  1 each  ID instruction actually reads rs1/rs2
- i_id_rd_addr  in  5  ID destination register
- i_id_rd_wren  in  1  ID instruction writes rd
- i_id_isload  in  1  ID instruction is a load (decoder isload)
- i_ex_mispred  in  1  EX resolved a branch/jump differently from the prediction
- i_mem_busy  in  1  LSU cannot complete this cycle; freeze the whole pipeline
- o_pc_en  out  1  PC register update enable
- o_if_id_en  out  1  IF/ID register enable
- o_if_id_flush  out  1  IF/ID loads a bubble
- o_id_ex_en  out  1  ID/EX register enable
- o_id_ex_flush  out  1  ID/EX loads a bubble
- o_fwd_a_sel / o_fwd_b_sel  out  2 each  registered operand select for the instruction now in EX: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback data
- o_state  out  2  FSM state (debug)
- o_stall_cnt / o_flush_cnt  out  CNT_W each  performance counters

## Operation
- Shadow tracking registers:
  - EX stage: ex_vld, ex_rd, ex_wren, ex_isload.
  - MEM stage: mem_vld, mem_rd, mem_wren.
- Advance rule: on every non-frozen cycle, mem_* <= ex_*. ex_* <= id_* gated by i_id_vld, or all zero when o_id_ex_flush=1.
- Hazard match: the ID instruction hits a stage when that stage is valid, has wren=1, its rd != 0, and rd equals a used rs.
- Load-use: the ID instruction hits EX and ex_isload=1.
- FSM states: RUN=00, LDUSE=01, FREEZE=10.
- Priority, highest first:
  1. i_reset
  2. i_mem_busy: FREEZE. All enables 0, no flushes, tracking, forwarding and counters hold.
  3. i_ex_mispred: both flushes 1, o_pc_en=1 (redirect), load-use ignored.
  4. Load-use: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1. Next state is LDUSE.
  5. RUN: all enables 1, flushes 0.
- LDUSE lasts exactly one cycle:
  - The load is now in MEM and is no longer a load-use hit.
  - The consumer then proceeds with forwarding select 10.
  - From LDUSE, return to RUN unless a freeze or a new hazard occurs.
- FREEZE returns to the state held before the freeze when i_mem_busy drops.
- Forwarding selects are computed in ID and registered when o_id_ex_en=1:
  - EX hit gives 01; otherwise a MEM hit gives 10; otherwise 00. EX takes priority (youngest producer).
  - Flush or bubble clears the selects to 00.
- A WB-stage producer versus an ID consumer is not forwarded here. The register file provides the same-cycle write-to-read bypass.
- Enables and flushes are combinational from inputs and registered state. Forwarding selects, state and counters are registered.

## Timing
- Reset (clock edge with i_reset=1) sets:
  - all tracking registers to 0
  - state RUN
  - o_fwd_a_sel = o_fwd_b_sel = 00
  - both counters to 0
- While i_reset=1, the outputs are: o_pc_en=0, o_if_id_en=1, o_id_ex_en=1, o_if_id_flush=1, o_id_ex_flush=1.
- Reset asserted mid-stall or mid-freeze aborts it. The first cycle after reset is RUN with empty tracking.
- Stall/flush reaction to ID/EX/LSU inputs: 0 cycles (same-cycle combinational).
- Forwarding select: valid the cycle the consumer enters EX, i.e. 1 cycle after the decision in ID.
- Load-use costs exactly 1 bubble. A mispredict costs 2 squashed slots (IF and ID).
- A mispredict and a load-use hit in the same cycle produce a flush only, with no stall.
- i_mem_busy together with i_ex_mispred: the freeze wins. The mispredict is taken on the first non-busy cycle; EX holds, so i_ex_mispred remains asserted.
- Counters saturate at all-ones and do not wrap.

## Configuration
- HAZARD_PERF_EN defined:
  - o_stall_cnt increments on every cycle that enters LDUSE.
  - o_flush_cnt increments on every non-frozen cycle with i_ex_mispred=1.
- HAZARD_PERF_EN undefined: no counter registers; both outputs tied to 0.

## Test plan
- Back-to-back ALU dependency (x5 written in EX, ID reads rs1=x5) -> no stall; o_fwd_a_sel=01 next cycle.
- One independent instruction between producer x7 and consumer reading rs2=x7 -> o_fwd_b_sel=10, no stall.
- Load x3 in EX, ID reads rs1=x3 -> 1 cycle of o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; state 01; then o_fwd_a_sel=10; o_stall_cnt=1.
- Producer rd=x0, consumer reads x0 -> fwd 00, no stall; mispredict in the same cycle as a load-use -> both flushes 1, o_pc_en=1, o_flush_cnt+1, o_stall_cnt unchanged.
- i_mem_busy held for 3 cycles during a load-use -> all enables 0 for 3 cycles, selects and counters hold; resume with correct forwarding.
- i_reset asserted in LDUSE -> next cycle state 00, selects 00, counters 0, tracking empty.
